// File: rtl/pc_unit_if.sv
// rtl/pc_unit_if.sv - control inputs and PC/status outputs of the program counter unit
interface pc_unit_if #(
  parameter int ADDR_W = 7
);
  logic              stall;
  logic              branch_taken;
  logic [ADDR_W-1:0] branch_target;
  logic              jump;
  logic [ADDR_W-1:0] jump_target;
  logic              trap;
  logic              mret;
  logic              halt;
  logic              resume;
  logic [ADDR_W-1:0] pc_out;
  logic [ADDR_W-1:0] pc_plus_inc;
  logic [ADDR_W-1:0] epc;
  logic              misalign;
  logic              halted;

  modport master (
    output stall, branch_taken, branch_target, jump, jump_target,
           trap, mret, halt, resume,
    input  pc_out, pc_plus_inc, epc, misalign, halted
  );

  modport slave (
    input  stall, branch_taken, branch_target, jump, jump_target,
           trap, mret, halt, resume,
    output pc_out, pc_plus_inc, epc, misalign, halted
  );
endinterface

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - program counter with redirect priority, trap/return, halt/resume
module pc_unit #(
  parameter int                ADDR_W    = 7,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter logic [ADDR_W-1:0] TRAP_VEC  = ADDR_W'(7'h40),
  parameter int unsigned       INC       = 4
) (
  input  logic        clk,
  input  logic        reset,
  pc_unit_if.slave    bus
);

  typedef enum logic {RUN, HALTED} state_t;

  localparam logic [ADDR_W-1:0] STEP        = ADDR_W'(INC);
  localparam bit                CHECK_ALIGN = (INC == 4);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_nxt;
  logic [ADDR_W-1:0] epc_r, epc_nxt;
  logic              mis, mis_nxt;
  logic [ADDR_W-1:0] seq_pc;

  assign seq_pc = pc + STEP;

  // Word alignment only makes sense when instructions are 4 bytes wide.
  function automatic logic misaligned(input logic [ADDR_W-1:0] t);
    return CHECK_ALIGN && (t[1:0] != 2'b00);
  endfunction

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    epc_nxt   = epc_r;
    mis_nxt   = 1'b0;
    case (state)
      RUN: begin
        if (bus.trap) begin
          pc_nxt  = TRAP_VEC;
          epc_nxt = pc;
        end else if (bus.mret) begin
          pc_nxt = epc_r;
        end else if (bus.jump) begin
          if (misaligned(bus.jump_target)) begin
            pc_nxt  = TRAP_VEC;
            epc_nxt = pc;
            mis_nxt = 1'b1;
          end else begin
            pc_nxt = bus.jump_target;
          end
        end else if (bus.branch_taken) begin
          if (misaligned(bus.branch_target)) begin
            pc_nxt  = TRAP_VEC;
            epc_nxt = pc;
            mis_nxt = 1'b1;
          end else begin
            pc_nxt = bus.branch_target;
          end
        end else if (bus.halt) begin
          state_nxt = HALTED;
        end else if (!bus.stall) begin
          pc_nxt = seq_pc;
        end
      end
      HALTED: begin
        // Only trap or resume leave HALTED; all redirects are ignored here.
        if (bus.trap) begin
          pc_nxt    = TRAP_VEC;
          epc_nxt   = pc;
          state_nxt = RUN;
        end else if (bus.resume) begin
          pc_nxt    = seq_pc;
          state_nxt = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      pc    <= RESET_VEC;
      epc_r <= '0;
      mis   <= 1'b0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      epc_r <= epc_nxt;
      mis   <= mis_nxt;
    end
  end

  assign bus.pc_out      = pc;
  assign bus.pc_plus_inc = seq_pc;
  assign bus.epc         = epc_r;
  assign bus.misalign    = mis;
  assign bus.halted      = (state == HALTED);

endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - directed bench with a reference model for pc_unit defaults
module tb_pc_unit;
  logic clk = 1'b0;
  logic reset;
  int   n_cmp  = 0;
  int   n_fail = 0;

  pc_unit_if #(.ADDR_W(7)) bus ();

  pc_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference state, expressed as integers with byte-address arithmetic.
  int m_pc, m_epc, m_mis, m_halted;
  bit m_valid = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bool_t_dummy(input int x);
    return x;
  endfunction

  always @(posedge clk) begin
    int next_pc, next_epc, next_mis, next_h;
    next_pc  = m_pc;
    next_epc = m_epc;
    next_mis = 0;
    next_h   = m_halted;
    if (reset) begin
      next_pc = 0; next_epc = 0; next_h = 0;
      m_valid = 1'b1;
    end else if (m_halted != 0) begin
      if (bus.trap) begin
        next_epc = m_pc; next_pc = 64; next_h = 0;
      end else if (bus.resume) begin
        next_pc = (m_pc + 4) % 128; next_h = 0;
      end
    end else if (bus.trap) begin
      next_epc = m_pc; next_pc = 64;
    end else if (bus.mret) begin
      next_pc = m_epc;
    end else if (bus.jump || bus.branch_taken) begin
      int tgt;
      tgt = bus.jump ? int'(bus.jump_target) : int'(bus.branch_target);
      if (tgt % 4 != 0) begin
        next_epc = m_pc; next_pc = 64; next_mis = 1;
      end else begin
        next_pc = tgt;
      end
    end else if (bus.halt) begin
      next_h = 1;
    end else if (!bus.stall) begin
      next_pc = (m_pc + 4) % 128;
    end
    m_pc = next_pc; m_epc = next_epc; m_mis = next_mis; m_halted = next_h;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_pc_out", int'(bus.pc_out), m_pc);
      chk("model_pc_plus_inc", int'(bus.pc_plus_inc), (m_pc + 4) % 128);
      chk("model_epc", int'(bus.epc), m_epc);
      chk("model_misalign", int'(bus.misalign), m_mis);
      chk("model_halted", int'(bus.halted), m_halted);
    end
  end

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.stall = 0; bus.branch_taken = 0; bus.branch_target = '0;
    bus.jump = 0; bus.jump_target = '0; bus.trap = 0; bus.mret = 0;
    bus.halt = 0; bus.resume = 0;
  endtask

  task automatic do_jump(input int tgt);
    bus.jump = 1; bus.jump_target = 7'(tgt);
    tick;
    idle_inputs;
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs;
    tick;
    chk("reset_pc", int'(bus.pc_out), 0);
    chk("reset_epc", int'(bus.epc), 0);
    chk("reset_halted", int'(bus.halted), 0);
    chk("reset_misalign", int'(bus.misalign), 0);
    reset = 1'b0;

    tick; chk("seq_pc_4", int'(bus.pc_out), 4);
    tick; chk("seq_pc_8", int'(bus.pc_out), 8);
    tick; chk("seq_pc_12", int'(bus.pc_out), 12);

    // trap beats a simultaneous misaligned jump; mret returns to 12
    bus.trap = 1; bus.jump = 1; bus.jump_target = 7'd34;
    tick; idle_inputs;
    chk("trap_pc", int'(bus.pc_out), 64);
    chk("trap_epc", int'(bus.epc), 12);
    chk("trap_no_misalign", int'(bus.misalign), 0);
    bus.mret = 1; tick; idle_inputs;
    chk("mret_pc", int'(bus.pc_out), 12);
    chk("mret_epc_kept", int'(bus.epc), 12);

    tick; chk("pre_halt_pc", int'(bus.pc_out), 16);
    bus.halt = 1; tick; idle_inputs;
    chk("halt_halted", int'(bus.halted), 1);
    chk("halt_pc", int'(bus.pc_out), 16);
    bus.branch_taken = 1; bus.branch_target = 7'd40; bus.jump = 1;
    bus.jump_target = 7'd8; bus.mret = 1; bus.stall = 1;
    tick; idle_inputs;
    chk("halted_ignore_redirect_pc", int'(bus.pc_out), 16);
    bus.resume = 1; tick; idle_inputs;
    chk("resume_pc", int'(bus.pc_out), 20);
    chk("resume_halted", int'(bus.halted), 0);

    do_jump(34);
    chk("misjump_pc", int'(bus.pc_out), 64);
    chk("misjump_epc", int'(bus.epc), 20);
    chk("misjump_misalign", int'(bus.misalign), 1);
    tick;
    chk("misalign_cleared", int'(bus.misalign), 0);
    chk("after_misjump_pc", int'(bus.pc_out), 68);

    do_jump(8);
    chk("jump_pc", int'(bus.pc_out), 8);
    bus.stall = 1; bus.branch_taken = 1; bus.branch_target = 7'd40;
    tick; idle_inputs;
    chk("branch_over_stall", int'(bus.pc_out), 40);
    bus.stall = 1; tick; idle_inputs;
    chk("stall_hold", int'(bus.pc_out), 40);

    bus.branch_taken = 1; bus.branch_target = 7'd6; tick; idle_inputs;
    chk("misbranch_pc", int'(bus.pc_out), 64);
    chk("misbranch_epc", int'(bus.epc), 40);
    chk("misbranch_misalign", int'(bus.misalign), 1);

    do_jump(124);
    chk("jump_124", int'(bus.pc_out), 124);
    tick; chk("wrap_pc", int'(bus.pc_out), 0);

    bus.halt = 1; tick; idle_inputs;
    bus.halt = 1; bus.resume = 1; tick; idle_inputs;
    chk("halt_resume_pc", int'(bus.pc_out), 4);
    chk("halt_resume_halted", int'(bus.halted), 0);
    bus.resume = 1; tick; idle_inputs;
    chk("resume_in_run_pc", int'(bus.pc_out), 8);
    chk("resume_in_run_halted", int'(bus.halted), 0);

    bus.halt = 1; tick; idle_inputs;
    bus.trap = 1; tick; idle_inputs;
    chk("halted_trap_pc", int'(bus.pc_out), 64);
    chk("halted_trap_epc", int'(bus.epc), 8);
    chk("halted_trap_halted", int'(bus.halted), 0);

    bus.halt = 1; tick; idle_inputs;
    reset = 1'b1; bus.trap = 1; bus.halt = 1; tick; idle_inputs;
    chk("reset_in_halt_pc", int'(bus.pc_out), 0);
    chk("reset_in_halt_halted", int'(bus.halted), 0);
    chk("reset_in_halt_epc", int'(bus.epc), 0);
    reset = 1'b0;
    tick; chk("post_reset_pc", int'(bus.pc_out), 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter ADDR_W, default 7, SHALL set the PC width in bits.
REQ-002 Parameter RESET_VEC, default 0, SHALL set the PC value loaded on reset.
REQ-003 Parameter TRAP_VEC, default 7'h40 truncated to ADDR_W (0 when ADDR_W=6), SHALL set the trap handler address.
REQ-004 Parameter INC, default 4, SHALL set the sequential increment.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 stall  in  1  hold PC (sequential advance only).
REQ-008 branch_taken  in  1  load branch_target.
REQ-009 branch_target  in  ADDR_W  branch destination.
REQ-010 jump  in  1  load jump_target.
REQ-011 jump_target  in  ADDR_W  jump destination.
REQ-012 trap  in  1  enter trap handler.
REQ-013 mret  in  1  return from trap to epc.
REQ-014 halt  in  1  request halt.
REQ-015 resume  in  1  leave halt.
REQ-016 pc_out  out  ADDR_W  current PC, registered.
REQ-017 pc_plus_inc  out  ADDR_W  pc_out+INC, combinational, modulo 2^ADDR_W.
REQ-018 epc  out  ADDR_W  saved exception PC, registered.
REQ-019 misalign  out  1  one-cycle pulse, registered, redirect target was misaligned.
REQ-020 halted  out  1  high while in HALTED state.

Function
REQ-021 All state SHALL update only on rising clk; no asynchronous paths.
REQ-022 States SHALL be RUN and HALTED; reset enters RUN.
REQ-023 In RUN, next-PC priority SHALL be: trap > mret > jump > branch_taken > halt > stall > sequential.
REQ-024 Trap: pc_out <= TRAP_VEC and epc <= pc_out, next cycle.
REQ-025 Mret: pc_out <= epc; epc unchanged.
REQ-026 Jump/branch: pc_out <= target if target[1:0]==0.
REQ-027 Misaligned jump/branch target (target[1:0]!=0) SHALL act as a trap: pc_out <= TRAP_VEC, epc <= pc_out, misalign <= 1 for exactly one cycle.
REQ-028 Alignment check SHALL only apply when INC==4; for other INC values no misalign is raised.
REQ-029 Sequential: pc_out <= pc_out+INC, wrapping modulo 2^ADDR_W (max value +INC wraps to low bits, no error).
REQ-030 Stall SHALL hold pc_out only when no trap/mret/jump/branch/halt is asserted; redirects override stall.
REQ-031 Halt (in RUN, no higher-priority event): go to HALTED, pc_out unchanged.
REQ-032 In HALTED, pc_out SHALL hold; branch/jump/mret/stall ignored.
REQ-033 In HALTED, trap SHALL exit to RUN with pc_out <= TRAP_VEC, epc <= pc_out.
REQ-034 In HALTED, resume without trap SHALL return to RUN with pc_out <= pc_out+INC the same edge.
REQ-035 halt and resume asserted together in HALTED SHALL resume; in RUN, resume alone is ignored.
REQ-036 Latency from any redirect input to pc_out SHALL be exactly one cycle.

Reset
REQ-037 Reset SHALL override all inputs including trap and halt.
REQ-038 On reset: pc_out=RESET_VEC, epc=0, misalign=0, halted=0, state RUN.
REQ-039 Reset asserted mid-halt or mid-redirect SHALL discard the pending operation.

Verification
REQ-040 Reset then 3 idle cycles (defaults) -> pc_out 0,4,8,12; halted=0, epc=0.
REQ-041 pc_out=124 (ADDR_W=7), idle -> pc_out=0 next cycle (wrap).
REQ-042 pc_out=8, stall=1 and branch_taken=1 target=40 -> pc_out=40; then stall=1 alone -> pc_out stays 40.
REQ-043 pc_out=20, jump=1 target=34 -> pc_out=TRAP_VEC(64), epc=20, misalign=1 one cycle then 0.
REQ-044 pc_out=12, trap=1 and jump=1 same cycle -> pc_out=64, epc=12; then mret -> pc_out=12.
REQ-045 pc_out=16, halt -> halted=1, pc_out 16 held through branch inputs; resume -> pc_out=20, halted=0; reset during halt -> pc_out=0, halted=0.
